decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, width of the PC carried alongside each instruction.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  fetched instruction word.
- in_pc  in  ADDR_W  PC of in_instr.
- flush  in  1  discard all held instructions.
- out_valid  out  1  decoded bundle available.
- out_ready  in  1  consumer (ALU control/execute) accepts.
- out_instr  out  32  instruction passthrough.
- out_pc  out  ADDR_W  PC passthrough.
- out_aluop  out  2  ALUOp field.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_uncond, out_alu_src  out  1 each  control bits.
- out_illegal  out  1  opcode not in table.

Function
REQ-003 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-004 SHALL register decode results; latency in_valid accept -> out_valid is exactly 1 cycle.
REQ-005 SHALL hold 2 entries, a main output register and a skid register; in_ready SHALL be a registered signal equal to "skid empty".
REQ-006 SHALL have states EMPTY (0 held), ONE (main full), TWO (main+skid full).
- EMPTY: accept -> ONE.
- ONE: accept & no pop -> TWO (into skid); pop & no accept -> EMPTY; accept & pop -> ONE (main replaced).
- TWO: pop -> ONE (skid moves to main, no accept since in_ready=0).
REQ-007 SHALL keep out_* stable while out_valid && !out_ready.
REQ-008 SHALL apply flush synchronously: next state EMPTY, out_valid=0, and any same-cycle input accept is discarded; flush dominates all other events.
REQ-009 SHALL decode 64-bit forms, first match wins:
- ADDI [31:23]=100100010: aluop 10, reg_write, alu_src.
- SUBI [31:23]=110100010: aluop 10, reg_write, alu_src.
- MOVZ [31:23]=110100101: aluop 10, reg_write, alu_src.
- CMP [31:24]=11101011: aluop 10, no reg_write.
- CBZ [31:24]=10110100: aluop 01, branch.
- B [31:26]=000101: aluop 01, uncond.
- LDUR [31:21]=11111000010: aluop 00, mem_read, reg_write, alu_src.
- STUR [31:21]=11111000000: aluop 00, mem_write, alu_src.
- none: all control bits 0, aluop 00, out_illegal=1.
REQ-010 SHALL never assert reg_write, mem_read or mem_write together with out_illegal.
REQ-011 SHALL pass in_pc and in_instr unchanged, with no width conversion of in_pc.

Reset
REQ-012 SHALL, with rst_n=0 at a clock edge, enter EMPTY; out_valid=0, in_ready=1; out_instr=0, out_pc=0, all control and out_aluop outputs 0.
REQ-013 SHALL give reset priority over flush and over the handshakes; reset mid-transfer discards held entries.

Structure
REQ-014 SHALL place opcode patterns, ALUOp encodings (00 mem, 01 branch, 10 arith) and the decoded-bundle struct in shared package cpu_pkg.
REQ-015 SHALL implement the 2-entry buffer as sub-module pipe_skid, parameterised on payload width; decode logic stays combinational in decode_stage, ahead of pipe_skid.

Verification
REQ-016 Reset: rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, all outputs 0.
REQ-017 Decode: in_instr=0x91000421 (ADDI), out_ready=1 -> next cycle out_valid=1, out_aluop=10, reg_write=1, alu_src=1, illegal=0.
REQ-018 Backpressure: out_ready=0, 2 instructions (CBZ 0xB4000040, then STUR 0xF8000020) -> in_ready=0 after the 2nd; out_* hold CBZ with aluop=01 and branch=1; out_ready=1 -> CBZ, then STUR with mem_write=1 on consecutive cycles.
REQ-019 Flush: state TWO with flush=1 and in_valid=1 together -> next cycle out_valid=0, in_ready=1, and the input word never appears at the output.
REQ-020 Illegal: in_instr=0x00000000 -> out_illegal=1, all control bits 0.
REQ-021 Streaming: in_valid=out_ready=1 for 100 random legal words -> 1 output per cycle after 1-cycle latency, in order, no loss or duplication.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the CPU pipeline.
//   - Opcode match patterns for the supported 64-bit instruction forms.
//   - ALUOp encodings: 00 memory, 01 branch, 10 arithmetic.
//   - decode_ctrl_t: the decoded control bundle that travels with every
//     instruction, plus decode_instr() which produces it from a 32-bit word.
package cpu_pkg;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;

    // Opcode fields, compared against the top bits of the instruction word.
    localparam logic [8:0]  OP_ADDI = 9'b100100010;   // [31:23]
    localparam logic [8:0]  OP_SUBI = 9'b110100010;   // [31:23]
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;   // [31:23]
    localparam logic [7:0]  OP_CMP  = 8'b11101011;    // [31:24]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;    // [31:24]
    localparam logic [5:0]  OP_B    = 6'b000101;      // [31:26]
    localparam logic [10:0] OP_LDUR = 11'b11111000010; // [31:21]
    localparam logic [10:0] OP_STUR = 11'b11111000000; // [31:21]

    typedef struct packed {
        logic [1:0] aluop;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       uncond;
        logic       alu_src;
        logic       illegal;
    } decode_ctrl_t;

    localparam int CTRL_W = $bits(decode_ctrl_t);

    // First match wins; anything unmatched is flagged illegal with every
    // control bit (including the state-changing ones) held at zero.
    function automatic decode_ctrl_t decode_instr(input logic [31:0] instr);
        decode_ctrl_t c;
        c = '0;
        if (instr[31:23] == OP_ADDI || instr[31:23] == OP_SUBI ||
            instr[31:23] == OP_MOVZ) begin
            c.aluop     = ALUOP_ARITH;
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
        end else if (instr[31:24] == OP_CMP) begin
            c.aluop = ALUOP_ARITH;
        end else if (instr[31:24] == OP_CBZ) begin
            c.aluop  = ALUOP_BRANCH;
            c.branch = 1'b1;
        end else if (instr[31:26] == OP_B) begin
            c.aluop  = ALUOP_BRANCH;
            c.uncond = 1'b1;
        end else if (instr[31:21] == OP_LDUR) begin
            c.aluop     = ALUOP_MEM;
            c.mem_read  = 1'b1;
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
        end else if (instr[31:21] == OP_STUR) begin
            c.aluop     = ALUOP_MEM;
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
        end else begin
            c.illegal = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_skid.sv
// Two-entry valid/ready pipeline buffer (main output register + skid).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           drop everything held; wins over both handshakes
//   in_valid/in_ready/in_data     upstream side; in_ready is registered
//                                 and equals "skid empty"
//   out_valid/out_ready/out_data  downstream side; out_data is the main
//                                 register and is stable while stalled
module pipe_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         accept, pop;

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Handshake outputs are registered copies of the next-state view.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes the fetched word combinationally and
// registers {instr, pc, control} into a two-entry skid buffer, giving a
// one-cycle accept-to-valid latency with full-throughput streaming.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          fetch handshake, in_instr + in_pc payload
//   flush                      discard every held instruction
//   out_valid/out_ready        execute handshake
//   out_instr, out_pc          passthrough of the accepted word and PC
//   out_aluop, out_* bits      decoded control, out_illegal for unknown ops
module decode_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [1:0]        out_aluop,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_branch,
    output logic              out_uncond,
    output logic              out_alu_src,
    output logic              out_illegal
);
    localparam int PAYLOAD_W = 32 + ADDR_W + CTRL_W;

    decode_ctrl_t         in_ctrl;
    decode_ctrl_t         out_ctrl;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    assign in_ctrl    = decode_instr(in_instr);
    assign in_payload = {in_instr, in_pc, in_ctrl};

    pipe_skid #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {out_instr, out_pc, out_ctrl} = out_payload;

    assign out_aluop     = out_ctrl.aluop;
    assign out_reg_write = out_ctrl.reg_write;
    assign out_mem_read  = out_ctrl.mem_read;
    assign out_mem_write = out_ctrl.mem_write;
    assign out_branch    = out_ctrl.branch;
    assign out_uncond    = out_ctrl.uncond;
    assign out_alu_src   = out_ctrl.alu_src;
    assign out_illegal   = out_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a queue-based occupancy model plus a
// mask/match opcode table predict every output each cycle; directed
// sequences pin reset, decode, backpressure, flush, illegal and streaming.
module tb_decode_stage;
    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [ADDR_W-1:0] in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [1:0]        out_aluop;
    logic              out_reg_write, out_mem_read, out_mem_write;
    logic              out_branch, out_uncond, out_alu_src, out_illegal;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    decode_stage #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_aluop     (out_aluop),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_branch    (out_branch),
        .out_uncond    (out_uncond),
        .out_alu_src   (out_alu_src),
        .out_illegal   (out_illegal)
    );

    // Opcode table: ADDI SUBI MOVZ CMP CBZ B LDUR STUR, then "none".
    logic [31:0] tb_mask  [8] = '{32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000,
                                  32'hFF00_0000, 32'hFF00_0000, 32'hFC00_0000,
                                  32'hFFE0_0000, 32'hFFE0_0000};
    logic [31:0] tb_match [8] = '{32'h9100_0000, 32'hD100_0000, 32'hD280_0000,
                                  32'hEB00_0000, 32'hB400_0000, 32'h1400_0000,
                                  32'hF840_0000, 32'hF800_0000};
    logic [1:0] e_aluop [9] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    bit         e_rw    [9] = '{1, 1, 1, 0, 0, 0, 1, 0, 0};
    bit         e_mr    [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit         e_mw    [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit         e_br    [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    bit         e_un    [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    bit         e_as    [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 0};

    function automatic int classify(input logic [31:0] w);
        for (int k = 0; k < 8; k++)
            if ((w & tb_mask[k]) == tb_match[k]) return k;
        return 8;
    endfunction

    function automatic logic [8:0] expect_ctrl(input logic [31:0] w);
        int k;
        k = classify(w);
        return {e_aluop[k], e_rw[k], e_mr[k], e_mw[k], e_br[k], e_un[k], e_as[k], k == 8};
    endfunction

    function automatic logic [31:0] legal_word();
        int k;
        k = $urandom_range(0, 7);
        return ($urandom & ~tb_mask[k]) | tb_match[k];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of at most two instructions.
    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } ent_t;
    ent_t mq[$];

    always @(posedge clk) begin
        bit acc, pp;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2);
            pp  = (mq.size() > 0) && out_ready;
            if (pp) begin
                $display("[TB] out instr=%08h pc=%0h", mq[0].instr, mq[0].pc);
                void'(mq.pop_front());
            end
            if (acc) mq.push_back('{instr: in_instr, pc: in_pc});
        end
    end

    logic [8:0] dut_ctrl;
    assign dut_ctrl = {out_aluop, out_reg_write, out_mem_read, out_mem_write,
                       out_branch, out_uncond, out_alu_src, out_illegal};

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", in_ready, mq.size() < 2);
            chk("m_out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("m_instr", out_instr, mq[0].instr);
                chk("m_pc", out_pc, mq[0].pc);
                chk("m_ctrl", dut_ctrl, expect_ctrl(mq[0].instr));
            end
        end
    end

    logic [31:0] sw [100];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_ctrl", dut_ctrl, 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // ADDI decode, one-cycle latency
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h9100_0421; in_pc = 64'h1000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("addi_valid", out_valid, 1);
        chk("addi_aluop", out_aluop, 2'b10);
        chk("addi_rw", out_reg_write, 1);
        chk("addi_alusrc", out_alu_src, 1);
        chk("addi_illegal", out_illegal, 0);
        @(negedge clk);

        // Backpressure: CBZ then STUR with out_ready low
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hB400_0040; in_pc = 64'h2000;
        @(negedge clk);
        in_instr = 32'hF800_0020; in_pc = 64'h2004;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_instr", out_instr, 32'hB400_0040);
        chk("bp_aluop", out_aluop, 2'b01);
        chk("bp_branch", out_branch, 1);
        @(negedge clk);
        chk("bp_hold_instr", out_instr, 32'hB400_0040);
        chk("bp_hold_pc", out_pc, 64'h2000);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_stur_valid", out_valid, 1);
        chk("bp_stur_instr", out_instr, 32'hF800_0020);
        chk("bp_stur_mw", out_mem_write, 1);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Flush while TWO, with a simultaneous input offer
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hD100_0001; in_pc = 64'h3000;
        @(negedge clk);
        in_instr = 32'hEB00_0002; in_pc = 64'h3004;
        @(negedge clk);
        chk("fl_two", in_ready, 0);
        flush = 1'b1; in_instr = 32'hD281_2345; in_pc = 64'h3008;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("fl_gone", out_valid, 0);
        end

        // Illegal opcode
        in_valid = 1'b1; in_instr = 32'h0000_0000; in_pc = 64'h4000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", out_illegal, 1);
        chk("ill_ctrl", dut_ctrl, 9'b0_0000_0001);
        @(negedge clk);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 24) == 0);
            in_instr  = ($urandom_range(0, 3) == 0) ? $urandom : legal_word();
            in_pc     = {$urandom, $urandom};
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Full-rate streaming of 100 legal words
        for (int i = 0; i < 100; i++) sw[i] = legal_word();
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                chk("st_valid", out_valid, 1);
                chk("st_instr", out_instr, sw[i-1]);
                chk("st_in_ready", in_ready, 1);
            end
            in_valid = 1'b1; in_instr = sw[i]; in_pc = 64'h8000 + 64'(4 * i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("st_last", out_instr, sw[99]);
        @(negedge clk);
        chk("st_end", out_valid, 0);

        // Reset in the middle of a held pair beats a same-cycle accept
        out_ready = 1'b0; in_valid = 1'b1; in_instr = legal_word(); in_pc = 64'h9000;
        @(negedge clk);
        in_instr = legal_word(); in_pc = 64'h9004;
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_out_instr", out_instr, 0);
        chk("mr_ctrl", dut_ctrl, 0);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mr_after", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
